// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename labels.
// Issue maps rd to a ROB label; commit writes data and retires the label.
module reg_file_rename #(
  parameter int ROB_ID_WIDTH = 3,
  parameter int REG_WIDTH    = 5,
  parameter int VAL_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  issue_en,
  input  logic [REG_WIDTH-1:0]  issue_rd,
  input  logic [ROB_ID_WIDTH:0] issue_lab,
  input  logic [REG_WIDTH-1:0]  rs1,
  input  logic [REG_WIDTH-1:0]  rs2,
  input  logic                  commit_en,
  input  logic [REG_WIDTH-1:0]  commit_rd,
  input  logic [VAL_WIDTH-1:0]  commit_res,
  input  logic [ROB_ID_WIDTH:0] commit_lab,
  output logic [ROB_ID_WIDTH:0] rf_label1,
  output logic [ROB_ID_WIDTH:0] rf_label2,
  output logic [VAL_WIDTH-1:0]  rf_val1,
  output logic [VAL_WIDTH-1:0]  rf_val2
);

  localparam int NREG = 1 << REG_WIDTH;

  logic [VAL_WIDTH-1:0]  val_q [NREG];
  logic [ROB_ID_WIDTH:0] lab_q [NREG];

  logic commit_ok;
  logic issue_ok;
  logic clr_ok;

  assign commit_ok = rdy_in && commit_en
                   && (commit_rd != '0);
  assign issue_ok  = rdy_in && issue_en
                   && !flush_in
                   && (issue_rd != '0);
  assign clr_ok    = commit_ok
                   && (lab_q[commit_rd] == commit_lab);

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        lab_q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (commit_ok)
        val_q[commit_rd] <= commit_res;
      if (clr_ok)
        lab_q[commit_rd] <= '0;
      // issue is younger than commit, so its label wins
      if (issue_ok)
        lab_q[issue_rd] <= issue_lab;
      if (flush_in)
        for (int i = 0; i < NREG; i++)
          lab_q[i] <= '0;
    end
  end

  logic byp1;
  logic byp2;

  assign byp1 = rst_in && commit_en && !flush_in
              && (commit_rd == rs1)
              && (lab_q[rs1] == commit_lab);
  assign byp2 = rst_in && commit_en && !flush_in
              && (commit_rd == rs2)
              && (lab_q[rs2] == commit_lab);

  always_comb begin
    rf_label1 = '0;
    rf_val1   = '0;
    if (rs1 != '0) begin
      if (byp1) begin
        rf_val1 = commit_res;
      end else begin
        rf_label1 = lab_q[rs1];
        rf_val1   = val_q[rs1];
      end
    end
  end

  always_comb begin
    rf_label2 = '0;
    rf_val2   = '0;
    if (rs2 != '0) begin
      if (byp2) begin
        rf_val2 = commit_res;
      end else begin
        rf_label2 = lab_q[rs2];
        rf_val2   = val_q[rs2];
      end
    end
  end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags, shared by the decoder/issue path and the ROB commit path.
- On issue it maps the destination register to the ROB label of the issuing instruction.
- On commit it writes the result and releases the tag when the label still matches.
- Source reads return either a committed value (label 0) or the producing ROB label, which the ROB uses to build operand res/ready for the RS.

Parameters:
- ROB_ID_WIDTH, 3: label width is ROB_ID_WIDTH+1. Valid labels are 1..2**ROB_ID_WIDTH; 0 means "no pending producer".
- REG_WIDTH, 5: register index width (32 registers).
- VAL_WIDTH, 32: data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global enable; when low, no state changes.
- flush_in  in  1  ROB misprediction flush.
- issue_en  in  1  decoder issues an instruction this cycle.
- issue_rd  in  REG_WIDTH  destination register of the issuing instruction.
- issue_lab  in  ROB_ID_WIDTH+1  ROB tag (newTag) assigned to the issuing instruction.
- rs1  in  REG_WIDTH  source register 1 of the issuing instruction.
- rs2  in  REG_WIDTH  source register 2 of the issuing instruction.
- commit_en  in  1  ROB commits an instruction with a destination.
- commit_rd  in  REG_WIDTH  committed destination.
- commit_res  in  VAL_WIDTH  committed value.
- commit_lab  in  ROB_ID_WIDTH+1  label of the committing entry.
- rf_label1  out  ROB_ID_WIDTH+1  pending producer of rs1 (0 = none).
- rf_label2  out  ROB_ID_WIDTH+1  pending producer of rs2.
- rf_val1  out  VAL_WIDTH  value of rs1; meaningful when rf_label1 = 0.
- rf_val2  out  VAL_WIDTH  value of rs2.

Behaviour:
- Reset (rst_in = 0, async): all 32 values and labels cleared to 0. Outputs are therefore 0 during reset.
- State arrays: val[0..31] and lab[0..31]. x0 is hardwired: never written, its label is always 0, and reads of x0 always return 0/0.
- Reads are combinational on rs1/rs2 and reflect the mapping before this cycle's issue. An instruction with rs = rd = the same register sees the older producer, not itself.
- Read-commit bypass: if commit_en && commit_rd == rsX && commit_rd != 0 && lab[rsX] == commit_lab, then rf_labelX = 0 and rf_valX = commit_res in the same cycle.
- Otherwise rf_labelX = lab[rsX] and rf_valX = val[rsX].
- Bypass is inhibited when flush_in = 1; the read is discarded anyway, so it reports stored state.
- Commit (rdy_in && commit_en && commit_rd != 0):
  - val[commit_rd] <= commit_res.
  - lab[commit_rd] <= 0 only if lab[commit_rd] == commit_lab. A stale commit, where a younger producer is mapped, writes the value but keeps the label.
- Issue (rdy_in && issue_en && !flush_in && issue_rd != 0): lab[issue_rd] <= issue_lab.
- Simultaneous issue and commit to the same rd: the value is written and the label becomes issue_lab (issue wins over the clear).
- Flush (rdy_in && flush_in): every lab <= 0 and issue is ignored. A commit in the same cycle still writes its value, because the commit is older than the flush point.
- rdy_in = 0: no writes; combinational reads remain valid.
- Latency: a write is visible on the read ports the cycle after the edge. Commit data is also visible the same cycle via the bypass.
- issue_lab = 0 is illegal input; behaviour is unspecified and is flagged by a bench assertion.
- Labels wrap 1..2**ROB_ID_WIDTH in the ROB. This block does not interpret ordering and compares labels only for equality.

Test Plan:
- Reset, then rs1 = 5, rs2 = 0 -> rf_label1 = 0, rf_val1 = 0, rf_label2 = 0, rf_val2 = 0.
- Issue rd = 5 with lab = 3, next cycle read rs1 = 5 -> rf_label1 = 3. Then commit rd = 5, lab = 3, res = 0x1234 -> same cycle rf_label1 = 0, rf_val1 = 0x1234; next cycle stored state is lab 0, val 0x1234.
- Issue rd = 7 lab = 2, then issue rd = 7 lab = 4, then commit rd = 7 lab = 2 res = 9 -> val[7] = 9 and lab[7] stays 4; read rs1 = 7 gives rf_label1 = 4.
- Same cycle: issue rd = 6 lab = 5 and commit rd = 6 lab = 1 res = 0xAA (lab[6] was 1) -> next cycle lab[6] = 5, val[6] = 0xAA.
- Labels pending on x3 = 2 and x4 = 6; flush_in with commit rd = 3 lab = 2 res = 77 and issue rd = 8 lab = 7 -> all labels 0, val[3] = 77, x8 label stays 0.
- Issue or commit to rd = 0 with value 0xFFFF -> x0 reads label 0 and value 0. With rdy_in = 0 and issue rd = 9 lab = 3 -> lab[9] unchanged. Asserting rst_in low mid-sequence clears all state immediately, without waiting for a clock edge.
